stream_priority_encoder: RTL and testbench



---
 rtl/stream_priority_encoder.sv | 86 ++++++++
 tb/tb_stream_priority_encoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stream_priority_encoder.sv
// Stream priority encoder: captures a request vector and emits the index of each set
// bit, lowest first, one per output handshake. Define SPE_COUNT_EN to add out_count.
module stream_priority_encoder #(
  parameter int N_IN  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             empty_drop
`ifdef SPE_COUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_IN-1:0]   r_pend, w_pend_nxt;
  logic              r_drop;
  logic [N_IN-1:0]   w_rest;
  logic [IDX_W-1:0]  w_idx;
  logic              w_last;

  // Dropping the lowest set bit is exactly clearing pend[out_idx].
  assign w_rest = r_pend & (r_pend - N_IN'(1));
  assign w_last = (r_pend != '0) && (w_rest == '0);

  always_comb begin
    w_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (r_pend[i]) w_idx = IDX_W'(i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    case (r_state)
      IDLE: if (in_valid && in_vec != '0) begin
        w_pend_nxt  = in_vec;
        w_state_nxt = EMIT;
      end
      EMIT: if (out_ready) begin
        w_pend_nxt = w_rest;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_drop  <= (r_state == IDLE) && in_valid && (in_vec == '0);
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == EMIT);
  assign out_idx    = w_idx;
  assign out_last   = w_last;
  assign empty_drop = r_drop;

`ifdef SPE_COUNT_EN
  logic [IDX_W:0] w_cnt;
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_IN; i++)
      w_cnt = w_cnt + (IDX_W+1)'(r_pend[i]);
  end
  assign out_count = w_cnt;
`endif

endmodule

// File: tb/tb_stream_priority_encoder.sv
// Scoreboard bench for stream_priority_encoder: directed vectors push hand-computed
// indices; a negedge monitor pops and compares on every output handshake.
module tb_stream_priority_encoder;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] in_vec = '0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [2:0] out_idx;
  logic       out_last;
  logic       empty_drop;
`ifdef SPE_COUNT_EN
  logic [3:0] out_count;
`endif

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  stream_priority_encoder #(.N_IN(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .empty_drop(empty_drop)
`ifdef SPE_COUNT_EN
    , .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] idx, input logic last, input logic [3:0] cnt);
    q.push_back('{idx: idx, last: last, cnt: cnt});
  endtask

  // Monitor: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got idx %0d with empty scoreboard", out_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.last));
`ifdef SPE_COUNT_EN
        chk("out_count", 32'(out_count), 32'(e.cnt));
`endif
      end
    end
  end

  task automatic send(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin checks++; errors++; $display("FAIL send_timeout: in_ready 0 expected 1"); end
    in_valid = 1; in_vec = v;
    @(posedge clk); #1;
    in_valid = 0; in_vec = '0;
  endtask

  // Cycles from the first output cycle until in_ready returns.
  task automatic drain(input string name, input int exp_cycles);
    int k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk(name, 32'(k), 32'(exp_cycles));
  endtask

  initial begin
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_empty_drop", 32'(empty_drop), 0);
    #14 rst_n = 1;
    @(posedge clk); #1;

    // Reset mid-drain of A5 after indices 0 and 2.
    push(0, 0, 4); push(2, 0, 3); push(5, 0, 2); push(7, 1, 1);
    send(8'hA5);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0; #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_last", 32'(out_last), 0);
    chk("midrst_out_idx", 32'(out_idx), 0);
`ifdef SPE_COUNT_EN
    chk("midrst_out_count", 32'(out_count), 0);
`endif
    chk("midrst_remaining", 32'(q.size()), 2);
    q.delete();
    #3 rst_n = 1;
    @(posedge clk); #1;
    push(0, 1, 1);
    send(8'h01);
    drain("drain_01", 1);

    // Basic drain.
    push(1, 0, 3); push(4, 0, 2); push(6, 1, 1);
    send(8'b0101_0010);
    drain("drain_52", 3);

    // Stall.
    out_ready = 0;
    push(2, 0, 2); push(3, 1, 1);
    send(8'h0C);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_idx", 32'(out_idx), 2);
      chk("stall_last", 32'(out_last), 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    drain("drain_0C", 2);

    // Zero vector.
    send(8'h00);
    chk("zero_drop", 32'(empty_drop), 1);
    chk("zero_valid", 32'(out_valid), 0);
    chk("zero_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("zero_drop_clr", 32'(empty_drop), 0);
    chk("zero_valid2", 32'(out_valid), 0);

    // Full and MSB-only.
    for (int i = 0; i < 8; i++) push(3'(i), i == 7, 4'(8 - i));
    send(8'hFF);
    drain("drain_FF", 8);
    push(7, 1, 1);
    send(8'h80);
    drain("drain_80", 1);

    // Input blocking while draining 30.
    push(4, 0, 2); push(5, 1, 1); push(1, 1, 1);
    send(8'h30);
    in_valid = 1; in_vec = 8'h02;
    drain("block_accept", 2);
    @(posedge clk); #1;
    in_valid = 0; in_vec = '0;
    chk("block_taken", 32'(out_valid), 1);
    drain("drain_02", 1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
